// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter cell.
interface gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if;
    logic [3:0] REQ;
    logic       REL;
    logic [3:0] GNT;
    logic       VALID;
    logic [1:0] ID;
    logic       TOUT;

    modport master (output REQ, REL, input GNT, VALID, ID, TOUT);
    modport slave  (input REQ, REL, output GNT, VALID, ID, TOUT);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
// Four-requester round-robin arbiter with a forced turnaround gap and an ownership timeout.
module gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(
    parameter int TMO = 8
) (
    input  logic CLK,
    input  logic RN,
    inout  wire  VDD,
    inout  wire  VSS,
    gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if.slave bus
);
    localparam int N = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

    state_t       r_state, w_state_nx;
    logic [1:0]   r_ptr, w_ptr_nx;
    logic [7:0]   r_cnt, w_cnt_nx;
    logic [N-1:0] r_gnt, w_gnt_nx;
    logic         r_valid, w_valid_nx;
    logic [1:0]   r_id, w_id_nx;
    logic         r_tout, w_tout_nx;
    logic [1:0]   w_win;
    logic [1:0]   w_idx;
    logic         w_tmo_hit;
    logic         w_rel;
    logic         w_rst_n;

    // An unpowered cell is held in reset.
    assign w_rst_n   = RN & VDD & ~VSS;
    assign w_tmo_hit = (r_cnt == 8'(TMO));
    assign w_rel     = bus.REL || !bus.REQ[r_id] || w_tmo_hit;

    // Reverse scan so the last assignment is the first requester at or after PTR.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (bus.REQ[w_idx]) w_win = w_idx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_gnt_nx   = r_gnt;
        w_valid_nx = r_valid;
        w_id_nx    = r_id;
        w_tout_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.REQ) begin
                    w_gnt_nx   = 4'b0001 << w_win;
                    w_valid_nx = 1'b1;
                    w_id_nx    = w_win;
                    w_cnt_nx   = 8'd1;
                    w_state_nx = OWN;
                end
            end
            OWN: begin
                if (w_rel) begin
                    w_gnt_nx   = '0;
                    w_valid_nx = 1'b0;
                    w_ptr_nx   = r_id + 2'd1;
                    w_cnt_nx   = 8'd0;
                    // A voluntary release on the timeout cycle does not count as a timeout.
                    w_tout_nx  = w_tmo_hit && !bus.REL && bus.REQ[r_id];
                    w_state_nx = GAP;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            GAP:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_gnt   <= w_gnt_nx;
            r_valid <= w_valid_nx;
            r_id    <= w_id_nx;
            r_tout  <= w_tout_nx;
        end
    end

    assign bus.GNT   = r_gnt;
    assign bus.VALID = r_valid;
    assign bus.ID    = r_id;
    assign bus.TOUT  = r_tout;
endmodule
